cic_comb_seq: RTL
=================

// Module: cic_comb_seq
// PURPOSE
//  Time-multiplexed comb section for multi-channel CIC decimators. One shared subtractor
//  runs STAGES comb stages (y = x - x[n-M]) across CHANNELS channels.
//  Sits after the integrator/decimation strobe. Emits one comb-filtered word per channel,
//  serially, before the next decimated sample arrives.
// PARAMETERS
//  WIDTH     24  datapath width, two's complement; all arithmetic is modulo 2^WIDTH
//  CHANNELS   4  number of channels sharing the subtractor (>=1)
//  STAGES     5  comb stages per channel (>=1)
// PORTS
//  clock       in   1                 sole clock, rising edge
//  reset_n     in   1                 synchronous, active-low reset
//  in_strobe   in   1                 decimated sample valid, one-cycle pulse
//  in_data     in   CHANNELS*WIDTH    channel c at bits [c*WIDTH +: WIDTH]
//  out_strobe  out  1                 one-cycle pulse per finished channel
//  out_chan    out  clog2(CHANNELS)   channel index of out_data
//  out_data    out  WIDTH             comb output, signed
//  busy        out  1                 sequencer not in IDLE
//  overrun     out  1                 sticky: in_strobe dropped while busy
//  overrun_clr in   1                 clears overrun
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state=IDLE, out_strobe=0, out_chan=0, out_data=0, busy=0,
//    overrun=0, every delay element=0. Reset mid-RUN aborts the pass; no further out_strobe.
//  - FSM IDLE -> RUN -> IDLE.
//    IDLE: in_strobe latches in_data into a shadow register; ch=0, s=0, x=word0; go RUN.
//    RUN: one subtraction per clock. y = x - d[ch][s]; d[ch][s] <= x; x <= y.
//    If s==STAGES-1: register y into out_data and ch into out_chan, pulse out_strobe,
//    set s=0, x=word(ch+1), ch++. After the last channel, return to IDLE.
//  - Timing: strobe sampled at edge 0. Channel c output registered at edge (c+1)*STAGES.
//    busy=1 from edge 0 through edge CHANNELS*STAGES. Minimum strobe spacing is
//    CHANNELS*STAGES+1 clocks.
//  - in_strobe while busy: sample dropped, overrun<=1, pass in progress unaffected.
//    Simultaneous overrun_clr and a drop: set wins.
//  - out_data/out_chan hold their value between strobes.
//  - Overflow wraps silently; this is correct CIC behaviour given sufficient WIDTH.
// CONFIGURATION
//  CIC_COMB_SEQ_DM2_EN defined: differential delay M=2. Each element holds d1 and d2;
//    y = x - d2; d2 <= d1; d1 <= x. Storage doubles.
//  Undefined: M=1. Single delay element per (ch,s); y = x - d1.
// STRUCTURE
//  cic_comb_seq_pkg holds:
//    - FSM state encoding (S_IDLE, S_RUN)
//    - clog2 function
//    - index-width localparams CH_W and ST_W
//  Sub-module cic_comb_state_mem: CHANNELS*STAGES (x2 if DM2) flop array.
//    Combinational read and one write per clock, addressed {ch,s}, cleared by reset_n.
//  FSM, counters, shadow register, subtractor and output registers stay in the top.
// TESTING
//  - CH=2,ST=3,W=16: ch0 impulse 1 then 0,0,0; ch1 held 0
//      -> ch0 outputs 1,-3,3,-1, then 0; ch1 always 0.
//  - Constant 5 on all channels, ST=3 -> first pass outputs 5 per channel, later passes 0.
//      Out_strobe order is ch0,ch1 at edges 3,6.
//  - W=8, CH=1, ST=1: inputs 127 then -128 -> outputs 127 then 1 (modulo wrap).
//  - CH=2,ST=3: strobes at edges 0 and 3 -> second dropped, overrun=1, exactly 2 out_strobes.
//      overrun_clr -> overrun=0.
//  - Pulse reset_n low at edge 2 of a pass -> no out_strobe, busy=0 next cycle.
//      Next impulse yields 1 (delay state cleared).
//  - DM2 build, CH=1,ST=1: impulse -> 1,0,-1,0.
//      Non-DM2 build on same stimulus -> 1,-1,0.

Source files
------------

// File: rtl/cic_comb_seq_pkg.sv
// Shared types and helpers for the time-multiplexed CIC comb sequencer.
// Index widths below describe the default 4-channel, 5-stage build.
package cic_comb_seq_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // Never returns less than 1 so single-entry indices stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int CH_W = clog2(4);
  localparam int ST_W = clog2(5);

endpackage

// File: rtl/cic_comb_state_mem.sv
// Comb delay storage, one element per {channel, stage}, async read.
// CIC_COMB_SEQ_DM2_EN: two elements per slot for differential delay 2.
module cic_comb_state_mem
  import cic_comb_seq_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter int STAGES   = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       we,
  input  logic [clog2(CHANNELS)-1:0] ch,
  input  logic [clog2(STAGES)-1:0]   s,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           tap
);

  logic [WIDTH-1:0] d1 [CHANNELS][STAGES];

`ifdef CIC_COMB_SEQ_DM2_EN
  logic [WIDTH-1:0] d2 [CHANNELS][STAGES];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < STAGES; k++) begin
          d1[c][k] <= '0;
          d2[c][k] <= '0;
        end
    end else if (we) begin
      d1[ch][s] <= wdata;
      d2[ch][s] <= d1[ch][s];
    end
  end

  assign tap = d2[ch][s];
`else
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < STAGES; k++)
          d1[c][k] <= '0;
    end else if (we) begin
      d1[ch][s] <= wdata;
    end
  end

  assign tap = d1[ch][s];
`endif

endmodule

// File: rtl/cic_comb_seq.sv
// Multi-channel CIC comb section sharing one subtractor over all stages.
// CIC_COMB_SEQ_DM2_EN selects differential delay 2 (default 1).
module cic_comb_seq
  import cic_comb_seq_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter int STAGES   = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_strobe,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  output logic                       out_strobe,
  output logic [clog2(CHANNELS)-1:0] out_chan,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int CW = clog2(CHANNELS);
  localparam int SW = clog2(STAGES);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STAGES - 1);

  state_t state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [SW-1:0] s_q, s_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y, tap;
  logic [CHANNELS*WIDTH-1:0] sh_q, sh_d;
  logic we;
  logic ostb_d;
  logic [CW-1:0] ochan_d;
  logic [WIDTH-1:0] odata_d;
  logic ovr_d;

  cic_comb_state_mem #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .STAGES   (STAGES)
  ) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .ch      (ch_q),
    .s       (s_q),
    .wdata   (x_q),
    .tap     (tap)
  );

  assign y    = x_q - tap;
  assign busy = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    s_d     = s_q;
    x_d     = x_q;
    sh_d    = sh_q;
    we      = 1'b0;
    ostb_d  = 1'b0;
    ochan_d = out_chan;
    odata_d = out_data;
    ovr_d   = overrun;
    if (overrun_clr) ovr_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_strobe) begin
          state_d = S_RUN;
          sh_d    = in_data;
          x_d     = in_data[WIDTH-1:0];
          ch_d    = '0;
          s_d     = '0;
        end
      end
      S_RUN: begin
        // A strobe arriving mid-pass is lost; flag wins over clear.
        if (in_strobe) ovr_d = 1'b1;
        we  = 1'b1;
        x_d = y;
        s_d = s_q + 1'b1;
        if (s_q == ST_LAST) begin
          ostb_d  = 1'b1;
          odata_d = y;
          ochan_d = ch_q;
          s_d     = '0;
          if (ch_q == CH_LAST) begin
            state_d = S_IDLE;
          end else begin
            ch_d = ch_q + 1'b1;
            sh_d = sh_q >> WIDTH;
            x_d  = sh_d[WIDTH-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      s_q        <= '0;
      x_q        <= '0;
      sh_q       <= '0;
      out_strobe <= 1'b0;
      out_chan   <= '0;
      out_data   <= '0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      s_q        <= s_d;
      x_q        <= x_d;
      sh_q       <= sh_d;
      out_strobe <= ostb_d;
      out_chan   <= ochan_d;
      out_data   <= odata_d;
      overrun    <= ovr_d;
    end
  end

endmodule
